// File: rtl/rom_dl_router_pkg.sv
// Shared types and constants for the HPS download router.
// Also holds the checksum helper used when DL_CHECKSUM_EN is defined.
package rom_dl_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROM_LOAD = 2'd1,
        ST_DIP_LOAD = 2'd2,
        ST_HOLD     = 2'd3
    } dl_state_t;

    localparam logic [7:0] ROM_INDEX_DEF  = 8'd0;
    localparam logic [7:0] DIP_INDEX_DEF  = 8'd254;
    localparam int         DIP_BYTES      = 8;
    localparam int         BYTE_COUNT_MAX = 131072;

    function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] data);
        return sum + {8'd0, data};
    endfunction

    function automatic logic holds_core(input dl_state_t state);
        return (state == ST_ROM_LOAD) || (state == ST_HOLD);
    endfunction

endpackage

// File: rtl/dl_hold_timer.sv
// 8-bit down-counter that times the core-reset tail after a ROM load.
// expired is high for the single cycle in which a counting timer sits at zero.
module dl_hold_timer
    import rom_dl_router_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       count,
    output logic       expired
);

    logic [7:0] r_cnt;

    // Counter register: load has priority over decrement, stops at zero.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (load) begin
            r_cnt <= load_value;
        end else if (count && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign expired = count && !load && (r_cnt == 8'd0);

endmodule

// File: rtl/rom_dl_router.sv
// Routes ioctl downloads: ROM bytes to dl_* strobes, DIP bytes to dip_sw, core reset hold.
// Define DL_CHECKSUM_EN to build the running ROM checksum; otherwise rom_checksum is 0.
module rom_dl_router
    import rom_dl_router_pkg::*;
#(
    parameter int         ROM_BYTES  = 131072,
    parameter int         RESET_HOLD = 16,
    parameter logic [7:0] ROM_INDEX  = ROM_INDEX_DEF,
    parameter logic [7:0] DIP_INDEX  = DIP_INDEX_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic [63:0] dip_sw,
    output logic        core_reset,
    output logic        rom_busy,
    output logic        dl_done,
    output logic        rom_overflow,
    output logic [17:0] byte_count,
    output logic [15:0] rom_checksum
);

    localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);
    localparam logic [7:0]  HOLD_LOAD = 8'(RESET_HOLD - 1);
    localparam logic [17:0] COUNT_MAX = 18'(BYTE_COUNT_MAX);

    dl_state_t   r_state;
    dl_state_t   w_next;
    logic        r_dl_1;
    logic        r_dl_2;
    logic        w_rise;
    logic        w_fall;
    logic        w_rom_start;
    logic        w_rom_wr;
    logic        w_ovf_wr;
    logic        w_dip_wr;
    logic        w_expired;
    logic [16:0] r_dl_addr;
    logic [7:0]  r_dl_data;
    logic        r_dl_wr;
    logic [63:0] r_dip_sw;
    logic        r_core_reset;
    logic        r_rom_busy;
    logic        r_dl_done;
    logic        r_overflow;
    logic [17:0] r_byte_count;

    // Download flag pipeline; reset parks it high so a download in flight never looks like a new one.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_1 <= 1'b1;
            r_dl_2 <= 1'b1;
        end else begin
            r_dl_1 <= ioctl_download;
            r_dl_2 <= r_dl_1;
        end
    end

    assign w_rise = r_dl_1 && !r_dl_2;
    assign w_fall = !r_dl_1 && r_dl_2;

    // Next-state decode; the index is only consulted on a rising edge.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && (ioctl_index == ROM_INDEX)) begin
                    w_next = ST_ROM_LOAD;
                end else if (w_rise && (ioctl_index == DIP_INDEX)) begin
                    w_next = ST_DIP_LOAD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ROM_LOAD: begin
                if (w_fall) begin
                    w_next = ST_HOLD;
                end else begin
                    w_next = ST_ROM_LOAD;
                end
            end
            ST_DIP_LOAD: begin
                if (w_fall) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_DIP_LOAD;
                end
            end
            ST_HOLD: begin
                if (w_rise && (ioctl_index == ROM_INDEX)) begin
                    w_next = ST_ROM_LOAD;
                end else if (w_expired) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_HOLD;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_rom_start = (w_next == ST_ROM_LOAD) && (r_state != ST_ROM_LOAD);
    assign w_rom_wr    = (r_state == ST_ROM_LOAD) && ioctl_wr && (ioctl_addr < ROM_LIMIT);
    assign w_ovf_wr    = (r_state == ST_ROM_LOAD) && ioctl_wr && (ioctl_addr >= ROM_LIMIT);
    assign w_dip_wr    = (r_state == ST_DIP_LOAD) && ioctl_wr && (ioctl_addr[24:3] == 22'd0);

    dl_hold_timer u_hold_timer (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .load       ((r_state == ST_ROM_LOAD) && w_fall),
        .load_value (HOLD_LOAD),
        .count      (r_state == ST_HOLD),
        .expired    (w_expired)
    );

    // State register plus flags decoded from the next state so they line up with it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_core_reset <= 1'b0;
            r_rom_busy   <= 1'b0;
            r_dl_done    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_core_reset <= holds_core(w_next);
            r_rom_busy   <= (w_next == ST_ROM_LOAD);
            r_dl_done    <= (r_state == ST_HOLD) && (w_next == ST_IDLE);
        end
    end

    // ROM write path, overflow flag and saturating byte counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_wr      <= 1'b0;
            r_dl_addr    <= 17'd0;
            r_dl_data    <= 8'd0;
            r_overflow   <= 1'b0;
            r_byte_count <= 18'd0;
        end else begin
            r_dl_wr <= w_rom_wr;
            if (w_rom_wr) begin
                r_dl_addr <= ioctl_addr[16:0];
                r_dl_data <= ioctl_dout;
            end
            if (w_rom_start) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_wr) begin
                r_overflow <= 1'b1;
            end
            if (w_rom_start) begin
                r_byte_count <= 18'd0;
            end else if (w_rom_wr && (r_byte_count != COUNT_MAX)) begin
                r_byte_count <= r_byte_count + 18'd1;
            end
        end
    end

    // DIP bank: byte lane chosen by the low three address bits.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dip_sw <= 64'd0;
        end else if (w_dip_wr) begin
            r_dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Running sum of accepted ROM bytes, cleared when a ROM load starts.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_checksum <= 16'd0;
        end else if (w_rom_start) begin
            r_checksum <= 16'd0;
        end else if (w_rom_wr) begin
            r_checksum <= csum_add(r_checksum, ioctl_dout);
        end
    end

    assign rom_checksum = r_checksum;
`else
    assign rom_checksum = 16'd0;
`endif

    assign dl_addr      = r_dl_addr;
    assign dl_data      = r_dl_data;
    assign dl_wr        = r_dl_wr;
    assign dip_sw       = r_dip_sw;
    assign core_reset   = r_core_reset;
    assign rom_busy     = r_rom_busy;
    assign dl_done      = r_dl_done;
    assign rom_overflow = r_overflow;
    assign byte_count   = r_byte_count;

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router (ROM_BYTES=4, RESET_HOLD=16): per-cycle vector tables
// plus hand-written hold, restart and mid-load reset sequences.
module tb_rom_dl_router;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wr;
    logic [63:0] dip_sw;
    logic        core_reset;
    logic        rom_busy;
    logic        dl_done;
    logic        rom_overflow;
    logic [17:0] byte_count;
    logic [15:0] rom_checksum;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    rom_dl_router #(
        .ROM_BYTES  (4),
        .RESET_HOLD (16),
        .ROM_INDEX  (8'd0),
        .DIP_INDEX  (8'd254)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .dl_wr          (dl_wr),
        .dip_sw         (dip_sw),
        .core_reset     (core_reset),
        .rom_busy       (rom_busy),
        .dl_done        (dl_done),
        .rom_overflow   (rom_overflow),
        .byte_count     (byte_count),
        .rom_checksum   (rom_checksum)
    );

    typedef struct {
        logic        dl;
        logic [7:0]  idx;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        e_wr;
        logic [16:0] e_addr;
        logic [7:0]  e_data;
        logic        e_crst;
        logic        e_busy;
        logic        e_done;
        logic        e_ovf;
        logic [17:0] e_cnt;
        logic [63:0] e_dip;
        logic [15:0] e_sum;
    } vec_t;

    vec_t rom_tbl[9];
    vec_t dip_tbl[13];

    function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef DL_CHECKSUM_EN
        return s;
`else
        return 16'd0;
`endif
    endfunction

    function automatic vec_t mk(input logic dl, input logic [7:0] idx, input logic wr,
                                input logic [24:0] addr, input logic [7:0] dout,
                                input logic e_wr, input logic [16:0] e_addr, input logic [7:0] e_data,
                                input logic e_crst, input logic e_busy, input logic e_done,
                                input logic e_ovf, input logic [17:0] e_cnt,
                                input logic [63:0] e_dip, input logic [15:0] e_sum);
        vec_t v;
        v.dl = dl; v.idx = idx; v.wr = wr; v.addr = addr; v.dout = dout;
        v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
        v.e_crst = e_crst; v.e_busy = e_busy; v.e_done = e_done;
        v.e_ovf = e_ovf; v.e_cnt = e_cnt; v.e_dip = e_dip; v.e_sum = exp_sum(e_sum);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic dl, input logic [7:0] idx, input logic wr,
                         input logic [24:0] addr, input logic [7:0] dout);
        ioctl_download = dl;
        ioctl_index    = idx;
        ioctl_wr       = wr;
        ioctl_addr     = addr;
        ioctl_dout     = dout;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v.dl, v.idx, v.wr, v.addr, v.dout);
        step();
        chk({tag, " dl_wr"}, 64'(dl_wr), 64'(v.e_wr));
        if (v.e_wr) begin
            chk({tag, " dl_addr"}, 64'(dl_addr), 64'(v.e_addr));
            chk({tag, " dl_data"}, 64'(dl_data), 64'(v.e_data));
        end
        chk({tag, " core_reset"}, 64'(core_reset), 64'(v.e_crst));
        chk({tag, " rom_busy"}, 64'(rom_busy), 64'(v.e_busy));
        chk({tag, " dl_done"}, 64'(dl_done), 64'(v.e_done));
        chk({tag, " rom_overflow"}, 64'(rom_overflow), 64'(v.e_ovf));
        chk({tag, " byte_count"}, 64'(byte_count), 64'(v.e_cnt));
        chk({tag, " dip_sw"}, dip_sw, v.e_dip);
        chk({tag, " rom_checksum"}, 64'(rom_checksum), 64'(v.e_sum));
    endtask

    initial begin
        int hold_cycles;
        int done_seen;

        // ROM load: strobes 0..3, out-of-range at 4, index change mid-load ignored, then falling edge.
        rom_tbl[0] = mk(1'b1, 8'd0,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 64'd0, 16'h0000);
        rom_tbl[1] = mk(1'b1, 8'd0,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0, 64'd0, 16'h0000);
        rom_tbl[2] = mk(1'b1, 8'd0,   1'b1, 25'd0, 8'h11, 1'b1, 17'd0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 18'd1, 64'd0, 16'h0011);
        rom_tbl[3] = mk(1'b1, 8'd254, 1'b1, 25'd1, 8'h22, 1'b1, 17'd1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 18'd2, 64'd0, 16'h0033);
        rom_tbl[4] = mk(1'b1, 8'd254, 1'b1, 25'd2, 8'h33, 1'b1, 17'd2, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 18'd3, 64'd0, 16'h0066);
        rom_tbl[5] = mk(1'b1, 8'd254, 1'b1, 25'd3, 8'h44, 1'b1, 17'd3, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 18'd4, 64'd0, 16'h00AA);
        rom_tbl[6] = mk(1'b1, 8'd254, 1'b1, 25'd4, 8'h99, 1'b0, 17'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 18'd4, 64'd0, 16'h00AA);
        rom_tbl[7] = mk(1'b0, 8'd0,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 18'd4, 64'd0, 16'h00AA);
        rom_tbl[8] = mk(1'b0, 8'd0,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 18'd4, 64'd0, 16'h00AA);

        // DIP load (addr 1 kept, addr 9 dropped), then an index-5 download that must be ignored.
        dip_tbl[0]  = mk(1'b1, 8'd254, 1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'd0, 16'h00AA);
        dip_tbl[1]  = mk(1'b1, 8'd254, 1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'd0, 16'h00AA);
        dip_tbl[2]  = mk(1'b1, 8'd254, 1'b1, 25'd1, 8'h5A, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[3]  = mk(1'b1, 8'd254, 1'b1, 25'd9, 8'hFF, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[4]  = mk(1'b1, 8'd0,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[5]  = mk(1'b0, 8'd0,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[6]  = mk(1'b0, 8'd0,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[7]  = mk(1'b1, 8'd5,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[8]  = mk(1'b1, 8'd5,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[9]  = mk(1'b1, 8'd5,   1'b1, 25'd0, 8'hAB, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[10] = mk(1'b1, 8'd5,   1'b1, 25'd2, 8'hCD, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[11] = mk(1'b0, 8'd5,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);
        dip_tbl[12] = mk(1'b0, 8'd5,   1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 18'd4, 64'h5A00, 16'h00AA);

        reset = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 25'd0, 8'h00);
        repeat (3) step();
        chk("reset dl_wr", 64'(dl_wr), 64'd0);
        chk("reset dl_addr", 64'(dl_addr), 64'd0);
        chk("reset dl_data", 64'(dl_data), 64'd0);
        chk("reset dip_sw", dip_sw, 64'd0);
        chk("reset core_reset", 64'(core_reset), 64'd0);
        chk("reset rom_busy", 64'(rom_busy), 64'd0);
        chk("reset dl_done", 64'(dl_done), 64'd0);
        chk("reset rom_overflow", 64'(rom_overflow), 64'd0);
        chk("reset byte_count", 64'(byte_count), 64'd0);
        chk("reset rom_checksum", 64'(rom_checksum), 64'd0);
        reset = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 9; i++) apply(rom_tbl[i], $sformatf("rom[%0d]", i));

        // HOLD: core_reset high for 16 cycles counting the entry cycle, dl_done on return to IDLE.
        hold_cycles = 1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dl_done) done_seen++;
            if (!core_reset) begin
                chk("hold done_at_idle", 64'(dl_done), 64'd1);
                break;
            end
            hold_cycles++;
        end
        step();
        if (dl_done) done_seen++;
        chk("hold cycles", 64'(hold_cycles), 64'd16);
        chk("hold done_count", 64'(done_seen), 64'd1);
        chk("hold overflow_sticky", 64'(rom_overflow), 64'd1);

        for (int i = 0; i < 13; i++) apply(dip_tbl[i], $sformatf("dip[%0d]", i));

        // New ROM load interrupts HOLD: counters cleared, no dl_done.
        done_seen = 0;
        drive(1'b1, 8'd0, 1'b0, 25'd0, 8'h00);
        repeat (2) begin step(); if (dl_done) done_seen++; end
        chk("restart1 busy", 64'(rom_busy), 64'd1);
        chk("restart1 overflow_cleared", 64'(rom_overflow), 64'd0);
        chk("restart1 count", 64'(byte_count), 64'd0);
        chk("restart1 checksum", 64'(rom_checksum), 64'(exp_sum(16'h0000)));
        drive(1'b1, 8'd0, 1'b1, 25'd0, 8'h01);
        step();
        drive(1'b1, 8'd0, 1'b1, 25'd1, 8'h02);
        step();
        chk("restart1 count2", 64'(byte_count), 64'd2);
        drive(1'b0, 8'd0, 1'b0, 25'd0, 8'h00);
        repeat (2) begin step(); if (dl_done) done_seen++; end
        chk("restart hold core_reset", 64'(core_reset), 64'd1);
        chk("restart hold busy", 64'(rom_busy), 64'd0);
        repeat (3) begin step(); if (dl_done) done_seen++; end
        drive(1'b1, 8'd0, 1'b0, 25'd0, 8'h00);
        step();
        if (dl_done) done_seen++;
        chk("restart pre_edge busy", 64'(rom_busy), 64'd0);
        step();
        if (dl_done) done_seen++;
        chk("restart2 busy", 64'(rom_busy), 64'd1);
        chk("restart2 core_reset", 64'(core_reset), 64'd1);
        chk("restart2 count", 64'(byte_count), 64'd0);
        chk("restart2 checksum", 64'(rom_checksum), 64'(exp_sum(16'h0000)));
        repeat (2) begin step(); if (dl_done) done_seen++; end
        chk("restart no_done", 64'(done_seen), 64'd0);

        // Reset after two bytes: IDLE next cycle, remaining strobes ignored.
        drive(1'b1, 8'd0, 1'b1, 25'd0, 8'h10);
        step();
        drive(1'b1, 8'd0, 1'b1, 25'd1, 8'h20);
        step();
        chk("midrst count2", 64'(byte_count), 64'd2);
        chk("midrst checksum2", 64'(rom_checksum), 64'(exp_sum(16'h0030)));
        reset = 1'b1;
        drive(1'b1, 8'd0, 1'b0, 25'd0, 8'h00);
        step();
        reset = 1'b0;
        chk("midrst core_reset", 64'(core_reset), 64'd0);
        chk("midrst busy", 64'(rom_busy), 64'd0);
        chk("midrst count", 64'(byte_count), 64'd0);
        for (int i = 2; i < 4; i++) begin
            drive(1'b1, 8'd0, 1'b1, 25'(i), 8'(8'h30 + 8'(i)));
            step();
            chk($sformatf("midrst dl_wr[%0d]", i), 64'(dl_wr), 64'd0);
            chk($sformatf("midrst crst[%0d]", i), 64'(core_reset), 64'd0);
        end
        drive(1'b1, 8'd0, 1'b0, 25'd0, 8'h00);
        step();
        chk("midrst dl_wr_tail", 64'(dl_wr), 64'd0);
        drive(1'b0, 8'd0, 1'b0, 25'd0, 8'h00);
        repeat (3) step();
        chk("midrst end core_reset", 64'(core_reset), 64'd0);
        chk("midrst end count", 64'(byte_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
